multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath; replaces per-instruction one-shot decode.
//  Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB.
//  Drives PC, IR, register-file, ALU and memory enables each cycle.
//  Holds in memory states until memory signals mem_ready.
// PARAMETERS
//  RA_REG    5'd31  destination register for jal (applied by datapath when reg_dst=2'b10)
//  ST_W      4      state encoding width (state_o)
// PORTS
//  clk         in   1  rising-edge clock
//  rst_n       in   1  synchronous, active-low reset
//  opcode      in   6  Inst[31:26] from IR; valid from DECODE onward
//  zero        in   1  ALU zero flag (branch compare)
//  mem_ready   in   1  memory completes current access this cycle
//  ir_write    out  1  load IR from memory data
//  pc_write    out  1  load PC (unconditional or resolved branch)
//  pc_src      out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
//  iord        out  1  0 memory addr=PC, 1 addr=ALUOut
//  mem_read    out  1  memory read request
//  mem_write   out  1  memory write request
//  reg_write   out  1  register-file write enable
//  reg_dst     out  2  00 rt, 01 rd, 10 $31
//  mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
//  alu_src_a   out  1  0 PC, 1 rs
//  alu_src_b   out  2  00 rt, 01 const 4, 10 sign/zero imm, 11 imm<<2
//  alu_op      out  4  0000 add,0001 sub,0010 funct,0011 and,0100 or,0101 slt,0110 xor,0111 lui,1000 sgt
//  ori         out  1  zero-extend immediate (opcode 13 only)
//  instr_done  out  1  1-cycle pulse in an instruction's last state
//  illegal_op  out  1  1-cycle pulse in DECODE on unsupported opcode
//  state_o     out  4  current state (debug)
// BEHAVIOUR
//  - Moore outputs decoded from state and op_q; any output not listed for a state is 0.
//  - States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_MEM, WB_ALU, BRANCH, JUMP, JAL.
//  - Reset: rst_n=0 at a clk edge -> state IDLE, op_q=0. IDLE drives all outputs 0.
//    IDLE -> FETCH on the first edge with rst_n=1.
//  - Reset mid-instruction aborts at that edge: no write completes afterwards; a pending mem access is dropped.
//  - FETCH: mem_read=1, iord=0. Hold while mem_ready=0.
//    When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_op=0000. -> DECODE.
//  - DECODE: op_q<=opcode; alu_src_a=0, alu_src_b=11, alu_op=0000 (branch target into ALUOut).
//    Next state: 0->EXEC_R; 8,10..15->EXEC_I; 35,43->ADDR; 4,5->BRANCH; 2->JUMP; 3->JAL.
//    Any other opcode, including 32,33,40,41: illegal_op=1, instr_done=1 -> FETCH.
//  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=0010. -> WB_ALU.
//  - EXEC_I: alu_src_a=1, alu_src_b=10.
//    alu_op by op_q: 8->0000, 10->0101, 11->1000, 12->0011, 13->0100, 14->0110, 15->0111.
//    ori=1 iff op_q=13. -> WB_ALU.
//  - WB_ALU: reg_write=1, mem_to_reg=00, reg_dst=01 if op_q=0 else 00; instr_done. -> FETCH.
//  - ADDR: alu_src_a=1, alu_src_b=10, alu_op=0000. -> MEM_RD (35) or MEM_WR (43).
//  - MEM_RD: mem_read=1, iord=1; hold until mem_ready. -> WB_MEM.
//  - WB_MEM: reg_write=1, reg_dst=00, mem_to_reg=01; instr_done. -> FETCH.
//  - MEM_WR: mem_write=1, iord=1; hold until mem_ready.
//    On mem_ready: instr_done, -> FETCH. mem_write stays high continuously while waiting.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=0001, pc_src=01.
//    pc_write = (op_q==4 & zero) | (op_q==5 & ~zero); instr_done. -> FETCH.
//  - JUMP: pc_write=1, pc_src=10; instr_done. -> FETCH.
//  - JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10; instr_done. -> FETCH.
//    PC already holds PC+4 here.
//  - Latency with mem_ready always 1:
//    R/I-ALU 4, lw 5, sw 4, beq/bne/j/jal 3, illegal 2 cycles.
//  - mem_read and mem_write are never both 1; unencoded states go to IDLE.
// STRUCTURE
//  - Package mips_ctrl_pkg holds: opcode constants (OP_RTYPE..OP_SW), ALU_Op codes,
//    state enum, and pc_src/reg_dst/mem_to_reg/alu_src_b codes.
//  - Single module, no sub-modules: state register + op_q register + next-state/output combinational block.
// TESTING
//  - Reset: hold rst_n=0 3 cycles -> all outputs 0, state_o=IDLE.
//    Release -> FETCH next cycle with mem_read=1.
//  - R-type, opcode=0, mem_ready=1: ir_write on cycle 1, reg_write+reg_dst=01 on cycle 4, instr_done on cycle 4.
//  - lw with mem_ready low 3 cycles in MEM_RD: mem_read,iord held 4 cycles; WB_MEM reg_write, mem_to_reg=01; total 8 cycles.
//  - beq zero=1 -> pc_write=1, pc_src=01. bne zero=1 -> pc_write=0. Both finish in 3 cycles.
//  - ori (13): EXEC_I alu_op=0100, ori=1. opcode 32 -> illegal_op pulse in DECODE, then FETCH.
//  - Reset asserted during MEM_WR wait -> mem_write=0 next cycle, IDLE; no instr_done.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control sequencer.
// Holds opcode values, ALU operation codes, the state encoding and the
// datapath mux select codes, plus the bundled control-output struct.
package mips_ctrl_pkg;

    // Destination register for jal; the datapath applies it when reg_dst=RD_RA.
    localparam logic [4:0] RA_REG = 5'd31;
    localparam int         ST_W   = 4;

    // Opcodes (Inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_LUI   = 4'b0111;
    localparam logic [3:0] ALU_SGT   = 4'b1000;

    // State encoding
    localparam logic [ST_W-1:0] ST_IDLE   = 4'd0;
    localparam logic [ST_W-1:0] ST_FETCH  = 4'd1;
    localparam logic [ST_W-1:0] ST_DECODE = 4'd2;
    localparam logic [ST_W-1:0] ST_EXEC_R = 4'd3;
    localparam logic [ST_W-1:0] ST_EXEC_I = 4'd4;
    localparam logic [ST_W-1:0] ST_ADDR   = 4'd5;
    localparam logic [ST_W-1:0] ST_MEM_RD = 4'd6;
    localparam logic [ST_W-1:0] ST_MEM_WR = 4'd7;
    localparam logic [ST_W-1:0] ST_WB_MEM = 4'd8;
    localparam logic [ST_W-1:0] ST_WB_ALU = 4'd9;
    localparam logic [ST_W-1:0] ST_BRANCH = 4'd10;
    localparam logic [ST_W-1:0] ST_JUMP   = 4'd11;
    localparam logic [ST_W-1:0] ST_JAL    = 4'd12;

    // Mux select codes
    localparam logic [1:0] PC_ALU      = 2'b00;
    localparam logic [1:0] PC_ALUOUT   = 2'b01;
    localparam logic [1:0] PC_JUMP     = 2'b10;
    localparam logic [1:0] RD_RT       = 2'b00;
    localparam logic [1:0] RD_RD       = 2'b01;
    localparam logic [1:0] RD_RA       = 2'b10;
    localparam logic [1:0] M2R_ALU     = 2'b00;
    localparam logic [1:0] M2R_MDR     = 2'b01;
    localparam logic [1:0] M2R_PC      = 2'b10;
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       ori;
        logic       instr_done;
        logic       illegal_op;
    } ctl_t;

    // ALU operation for an immediate-form instruction.
    function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_SLTI:  return ALU_SLT;
            OP_SLTIU: return ALU_SGT;
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            OP_XORI:  return ALU_XOR;
            OP_LUI:   return ALU_LUI;
            default:  return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS datapath.
// Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives the
// PC, IR, register-file, ALU and memory controls each cycle.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   opcode, zero          IR opcode (valid from DECODE on), ALU zero flag
//   mem_ready             memory completes the current access this cycle
//   ir_write..ori         datapath control outputs
//   instr_done            pulse in an instruction's last state
//   illegal_op            pulse in DECODE on an unsupported opcode
//   state_o               current state (debug)
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic [1:0]      reg_dst,
    output logic [1:0]      mem_to_reg,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [3:0]      alu_op,
    output logic            ori,
    output logic            instr_done,
    output logic            illegal_op,
    output logic [ST_W-1:0] state_o
);

    logic [ST_W-1:0] state, state_n;
    logic [5:0]      op_q;
    ctl_t            c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= '0;
        end else begin
            state <= state_n;
            // IR is stable from DECODE on; capture once so later states
            // don't depend on the opcode input.
            if (state == ST_DECODE)
                op_q <= opcode;
        end
    end

    always_comb begin
        c       = '0;
        state_n = ST_IDLE;
        case (state)
            ST_IDLE: state_n = ST_FETCH;

            ST_FETCH: begin
                c.mem_read = 1'b1;
                state_n    = ST_FETCH;
                if (mem_ready) begin
                    // IR load and PC+4 happen together on the completing cycle
                    c.ir_write  = 1'b1;
                    c.pc_write  = 1'b1;
                    c.pc_src    = PC_ALU;
                    c.alu_src_b = SRCB_FOUR;
                    c.alu_op    = ALU_ADD;
                    state_n     = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_op    = ALU_ADD;
                case (opcode)
                    OP_RTYPE:                 state_n = ST_EXEC_R;
                    OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI:  state_n = ST_EXEC_I;
                    OP_LW, OP_SW:             state_n = ST_ADDR;
                    OP_BEQ, OP_BNE:           state_n = ST_BRANCH;
                    OP_J:                     state_n = ST_JUMP;
                    OP_JAL:                   state_n = ST_JAL;
                    default: begin
                        c.illegal_op = 1'b1;
                        c.instr_done = 1'b1;
                        state_n      = ST_FETCH;
                    end
                endcase
            end

            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALU_FUNCT;
                state_n     = ST_WB_ALU;
            end

            ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = imm_alu_op(op_q);
                c.ori       = (op_q == OP_ORI);
                state_n     = ST_WB_ALU;
            end

            ST_WB_ALU: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_ALU;
                c.reg_dst    = (op_q == OP_RTYPE) ? RD_RD : RD_RT;
                c.instr_done = 1'b1;
                state_n      = ST_FETCH;
            end

            ST_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                state_n     = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end

            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
                state_n    = mem_ready ? ST_WB_MEM : ST_MEM_RD;
            end

            ST_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = RD_RT;
                c.mem_to_reg = M2R_MDR;
                c.instr_done = 1'b1;
                state_n      = ST_FETCH;
            end

            ST_MEM_WR: begin
                c.mem_write  = 1'b1;
                c.iord       = 1'b1;
                c.instr_done = mem_ready;
                state_n      = mem_ready ? ST_FETCH : ST_MEM_WR;
            end

            ST_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_RT;
                c.alu_op     = ALU_SUB;
                c.pc_src     = PC_ALUOUT;
                c.pc_write   = ((op_q == OP_BEQ) &&  zero) ||
                               ((op_q == OP_BNE) && !zero);
                c.instr_done = 1'b1;
                state_n      = ST_FETCH;
            end

            ST_JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_src     = PC_JUMP;
                c.instr_done = 1'b1;
                state_n      = ST_FETCH;
            end

            ST_JAL: begin
                // PC already holds PC+4, which is the link value
                c.pc_write   = 1'b1;
                c.pc_src     = PC_JUMP;
                c.reg_write  = 1'b1;
                c.reg_dst    = RD_RA;
                c.mem_to_reg = M2R_PC;
                c.instr_done = 1'b1;
                state_n      = ST_FETCH;
            end

            default: state_n = ST_IDLE;
        endcase
    end

    assign ir_write   = c.ir_write;
    assign pc_write   = c.pc_write;
    assign pc_src     = c.pc_src;
    assign iord       = c.iord;
    assign mem_read   = c.mem_read;
    assign mem_write  = c.mem_write;
    assign reg_write  = c.reg_write;
    assign reg_dst    = c.reg_dst;
    assign mem_to_reg = c.mem_to_reg;
    assign alu_src_a  = c.alu_src_a;
    assign alu_src_b  = c.alu_src_b;
    assign alu_op     = c.alu_op;
    assign ori        = c.ori;
    assign instr_done = c.instr_done;
    assign illegal_op = c.illegal_op;
    assign state_o    = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Each instruction is expanded
// into its expected per-cycle control sequence from the instruction class,
// and the total cycle count is also checked against the latency table.
module tb_multicycle_ctrl_fsm;
    import mips_ctrl_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [5:0]      opcode = '0;
    logic            zero = 1'b0;
    logic            mem_ready = 1'b0;
    logic            ir_write, pc_write, iord, mem_read, mem_write, reg_write;
    logic            alu_src_a, ori, instr_done, illegal_op;
    logic [1:0]      pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [3:0]      alu_op;
    logic [ST_W-1:0] state_o;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       ori;
        logic       instr_done;
        logic       illegal_op;
    } exp_t;

    multicycle_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .ori(ori),
        .instr_done(instr_done), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        exp_t a;
        a = '{ir_write, pc_write, pc_src, iord, mem_read, mem_write, reg_write,
              reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, ori,
              instr_done, illegal_op};
        return a;
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd10, 6'd11,
                          6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};
    endfunction

    function automatic bit is_imm(input logic [5:0] op);
        return op inside {6'd8, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15};
    endfunction

    function automatic logic [3:0] imm_op_ref(input logic [5:0] op);
        case (op)
            6'd10:   return 4'b0101;
            6'd11:   return 4'b1000;
            6'd12:   return 4'b0011;
            6'd13:   return 4'b0100;
            6'd14:   return 4'b0110;
            6'd15:   return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    // Cycles from FETCH entry to the instr_done cycle, all-ready memory.
    function automatic int base_latency(input logic [5:0] op);
        if (!is_legal(op))                   return 2;
        if (op == 6'd35)                     return 5;
        if (op == 6'd0 || is_imm(op) || op == 6'd43) return 4;
        return 3;
    endfunction

    // One clock: drive inputs, sample outputs mid-cycle, advance.
    task automatic cycle(input logic mr, input logic [5:0] opc, input logic zf,
                         input exp_t e, input string tag);
        exp_t a;
        mem_ready = mr;
        opcode    = opc;
        zero      = zf;
        #2;
        a = observed();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d ctl got=%h expected=%h", tag, ncyc, a, e);
        end
        checks++;
        if (mem_read && mem_write) begin
            errors++;
            $display("FAIL %s cyc=%0d rd_wr_both got=1 expected=0", tag, ncyc);
        end
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic zf, input int fwait,
                             input int mwait, input string tag);
        exp_t e;
        int   start;
        int   mw;
        start = ncyc;
        mw    = (op == 6'd35 || op == 6'd43) ? mwait : 0;
        for (int i = 0; i < fwait; i++) begin
            e = '0; e.mem_read = 1'b1;
            cycle(1'b0, rop(), rbit(), e, tag);
        end
        e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        e.alu_src_b = 2'b01;
        cycle(1'b1, rop(), rbit(), e, tag);
        e = '0; e.alu_src_b = 2'b11;
        if (!is_legal(op)) begin e.illegal_op = 1'b1; e.instr_done = 1'b1; end
        cycle(rbit(), op, rbit(), e, tag);
        if (op == 6'd0 || is_imm(op)) begin
            e = '0; e.alu_src_a = 1'b1;
            if (op == 6'd0) e.alu_op = 4'b0010;
            else begin
                e.alu_src_b = 2'b10; e.alu_op = imm_op_ref(op); e.ori = (op == 6'd13);
            end
            cycle(rbit(), rop(), rbit(), e, tag);
            e = '0; e.reg_write = 1'b1; e.reg_dst = (op == 6'd0) ? 2'b01 : 2'b00;
            e.instr_done = 1'b1;
            cycle(rbit(), rop(), rbit(), e, tag);
        end else if (op == 6'd35 || op == 6'd43) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            cycle(rbit(), rop(), rbit(), e, tag);
            e = '0; e.iord = 1'b1;
            if (op == 6'd35) e.mem_read = 1'b1; else e.mem_write = 1'b1;
            for (int i = 0; i < mw; i++) cycle(1'b0, rop(), rbit(), e, tag);
            e.instr_done = (op == 6'd43);
            cycle(1'b1, rop(), rbit(), e, tag);
            if (op == 6'd35) begin
                e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.instr_done = 1'b1;
                cycle(rbit(), rop(), rbit(), e, tag);
            end
        end else if (op == 6'd4 || op == 6'd5) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_op = 4'b0001; e.pc_src = 2'b01;
            e.pc_write = (op == 6'd4) ? zf : !zf; e.instr_done = 1'b1;
            cycle(rbit(), rop(), zf, e, tag);
        end else if (op == 6'd2 || op == 6'd3) begin
            e = '0; e.pc_write = 1'b1; e.pc_src = 2'b10; e.instr_done = 1'b1;
            if (op == 6'd3) begin
                e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
            end
            cycle(rbit(), rop(), rbit(), e, tag);
        end
        checks++;
        if (ncyc - start != base_latency(op) + fwait + mw) begin
            errors++;
            $display("FAIL %s latency got=%0d expected=%0d", tag, ncyc - start,
                     base_latency(op) + fwait + mw);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state_o !== ST_IDLE) begin
                errors++;
                $display("FAIL reset_state got=%0d expected=%0d", state_o, ST_IDLE);
            end
            cycle(rbit(), rop(), rbit(), '0, "reset_outputs");
        end
        rst_n = 1'b1;
        cycle(rbit(), rop(), rbit(), '0, "idle_release");
        checks++;
        if (state_o !== ST_FETCH) begin
            errors++;
            $display("FAIL release_fetch got=%0d expected=%0d", state_o, ST_FETCH);
        end
    endtask

    task automatic test_directed();
        run_instr(6'd0,  1'b0, 0, 0, "rtype");
        run_instr(6'd35, 1'b0, 0, 3, "lw_wait3");
        run_instr(6'd4,  1'b1, 0, 0, "beq_taken");
        run_instr(6'd5,  1'b1, 0, 0, "bne_not_taken");
        run_instr(6'd4,  1'b0, 0, 0, "beq_not_taken");
        run_instr(6'd5,  1'b0, 0, 0, "bne_taken");
        run_instr(6'd13, 1'b0, 0, 0, "ori");
        run_instr(6'd32, 1'b0, 0, 0, "illegal32");
        run_instr(6'd41, 1'b0, 1, 0, "illegal41");
        run_instr(6'd43, 1'b0, 2, 2, "sw_wait2");
        run_instr(6'd2,  1'b0, 0, 0, "jump");
        run_instr(6'd3,  1'b0, 0, 0, "jal");
        run_instr(6'd15, 1'b0, 0, 0, "lui");
        run_instr(6'd11, 1'b0, 0, 0, "sltiu_sgt");
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        e.alu_src_b = 2'b01;
        cycle(1'b1, rop(), rbit(), e, "rst_wr_fetch");
        e = '0; e.alu_src_b = 2'b11;
        cycle(1'b0, 6'd43, rbit(), e, "rst_wr_decode");
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        cycle(1'b0, rop(), rbit(), e, "rst_wr_addr");
        e = '0; e.mem_write = 1'b1; e.iord = 1'b1;
        cycle(1'b0, rop(), rbit(), e, "rst_wr_wait");
        rst_n = 1'b0;
        cycle(1'b0, rop(), rbit(), e, "rst_wr_assert");
        rst_n = 1'b1;
        checks++;
        if (state_o !== ST_IDLE) begin
            errors++;
            $display("FAIL rst_wr_idle got=%0d expected=%0d", state_o, ST_IDLE);
        end
        cycle(1'b1, rop(), rbit(), '0, "rst_wr_dropped");
    endtask

    task automatic test_back_to_back();
        logic [5:0] legal_ops [14] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd10,
                                      6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};
        logic [5:0] op;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) op = rop();
            else op = legal_ops[$urandom_range(0, 13)];
            run_instr(op, rbit(), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
